// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: opcode codes, FSM state type and
// the status-flag bundle. Imported by seq_alu, seq_alu_iter and the bench.
// Optional feature macro used elsewhere in this slice: ALU_DIV_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Opcode codes; the top casts them to its SEL_WIDTH.
    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_MUL = 2;
    localparam int unsigned OP_PAS = 3;
    localparam int unsigned OP_AND = 4;
    localparam int unsigned OP_OR  = 5;
    localparam int unsigned OP_XOR = 6;
    localparam int unsigned OP_NOT = 7;
    localparam int unsigned OP_DIV = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Request/response bundle between the issue stage (master) and seq_alu (slave).
//   in_valid/in_ready/sel/a/b          : request channel
//   out_valid/out_ready/s/r/zero/carry/ovf : response channel
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high; once valid is raised the payload stays
// stable until that transfer, and ready may depend combinationally on the
// other side's signals but valid never depends on ready.
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] r;
    logic                  zero;
    logic                  carry;
    logic                  ovf;

    modport master (
        output in_valid, sel, a, b, out_ready,
        input  in_ready, out_valid, s, r, zero, carry, ovf
    );

    modport slave (
        input  in_valid, sel, a, b, out_ready,
        output in_ready, out_valid, s, r, zero, carry, ovf
    );
endinterface

// File: rtl/seq_alu_iter.sv
// -----------------------------------------------------------------------------
// seq_alu_iter
// Shared one-bit-per-cycle datapath for MUL (shift-add on the low HILO_WIDTH
// bits) and, when ALU_DIV_EN is defined, unsigned restoring DIV.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (aborts any op)
//   start      : one-cycle pulse, loads a/b and begins an op
//   is_div     : selects DIV for the op being started
//   a, b       : operands sampled on start
//   done       : high during the cycle whose edge performs the final step
//   res        : product / quotient after that final step (valid with done)
//   rem        : remainder after the final step (ALU_DIV_EN only)
// -----------------------------------------------------------------------------
module seq_alu_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int HILO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] res
`ifdef ALU_DIV_EN
    ,
    output logic [DATA_WIDTH-1:0] rem
`endif
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] LOW_MASK =
        {{(DATA_WIDTH-HILO_WIDTH){1'b0}}, {HILO_WIDTH{1'b1}}};

    logic                  busy;
    logic                  div_q;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         last;
    // acc: product accumulator (MUL) or partial remainder (DIV)
    // q  : multiplier shifting right (MUL) or dividend->quotient (DIV)
    // m  : multiplicand shifting left (MUL) or divisor (DIV)
    logic [DATA_WIDTH-1:0] acc, q, m;
    logic [DATA_WIDTH-1:0] acc_n, q_n, m_n;
`ifdef ALU_DIV_EN
    logic [DATA_WIDTH:0]   shifted, trial;
`endif

    assign last = div_q ? CW'(DATA_WIDTH - 1) : CW'(HILO_WIDTH - 1);
    assign done = busy && (cnt == last);
    // Results are taken from the step values so the top can capture them on
    // the very edge that performs the last step.
    assign res  = div_q ? q_n : acc_n;
`ifdef ALU_DIV_EN
    assign rem  = acc_n;
`endif

    always_comb begin
        acc_n = acc;
        q_n   = q;
        m_n   = m;
`ifdef ALU_DIV_EN
        // Remainder always stays below the divisor, so DATA_WIDTH bits hold it;
        // only the trial subtraction needs the extra top bit.
        shifted = {acc, q[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, m};
        if (div_q) begin
            acc_n = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
            q_n   = {q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
        end else
`endif
        begin
            if (q[0]) begin
                acc_n = acc + m;
            end
            m_n = m << 1;
            q_n = q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            div_q <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            div_q <= is_div;
            cnt   <= '0;
            acc   <= '0;
            if (is_div) begin
                q <= a;
                m <= b;
            end else begin
                q <= b & LOW_MASK;
                m <= a & LOW_MASK;
            end
        end else if (busy) begin
            acc <= acc_n;
            q   <= q_n;
            m   <= m_n;
            cnt <= cnt + 1'b1;
            if (cnt == last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Registered, handshaked ALU: one op in flight, result held until consumed.
// Single-cycle ops (ADD SUB PAS AND OR XOR NOT, undefined codes -> ~A) finish
// on the accept edge; MUL takes HILO_WIDTH+1 clocks; DIV (only when the macro
// ALU_DIV_EN is defined) takes DATA_WIDTH+1 clocks regardless of data.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seq_alu_if slave modport (request + response channels)
//   state_dbg  : current FSM state, for observation only
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int HILO_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_alu_if.slave        bus,
    output state_t          state_dbg
);

    if (2 * HILO_WIDTH > DATA_WIDTH) begin : g_bad_hilo
        $error("seq_alu: 2*HILO_WIDTH must not exceed DATA_WIDTH");
    end

    localparam int MSB = DATA_WIDTH - 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] s_q, r_q;
    flags_t                flags_q;

    logic                  accept;
    logic                  is_iter_c, is_div_c;
    logic [DATA_WIDTH:0]   sum, diff;
    logic [DATA_WIDTH-1:0] res_c;
    flags_t                flags_c;

    logic                  iter_done;
    logic [DATA_WIDTH-1:0] iter_res;
    flags_t                iter_flags;
`ifdef ALU_DIV_EN
    logic [DATA_WIDTH-1:0] iter_rem;
    logic                  div_q, div0_q;
`endif

    assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.zero      = flags_q.zero;
    assign bus.carry     = flags_q.carry;
    assign bus.ovf       = flags_q.ovf;
    assign state_dbg     = state;

    // Single-cycle datapath straight from the request channel; its result is
    // only registered on an accept edge.
    always_comb begin
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = {1'b0, bus.a} - {1'b0, bus.b};
        res_c     = ~bus.a;
        flags_c   = '0;
        is_iter_c = 1'b0;
        is_div_c  = 1'b0;
        case (bus.sel)
            SEL_WIDTH'(OP_ADD): begin
                res_c         = sum[MSB:0];
                flags_c.carry = sum[DATA_WIDTH];
                flags_c.ovf   = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            end
            SEL_WIDTH'(OP_SUB): begin
                res_c         = diff[MSB:0];
                flags_c.carry = diff[DATA_WIDTH];   // borrow
                flags_c.ovf   = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
            end
            SEL_WIDTH'(OP_MUL): is_iter_c = 1'b1;
            SEL_WIDTH'(OP_PAS): res_c = bus.a;
            SEL_WIDTH'(OP_AND): res_c = bus.a & bus.b;
            SEL_WIDTH'(OP_OR):  res_c = bus.a | bus.b;
            SEL_WIDTH'(OP_XOR): res_c = bus.a ^ bus.b;
            SEL_WIDTH'(OP_NOT): res_c = ~bus.a;
`ifdef ALU_DIV_EN
            SEL_WIDTH'(OP_DIV): begin
                is_iter_c = 1'b1;
                is_div_c  = 1'b1;
            end
`endif
            default: res_c = ~bus.a;
        endcase
        flags_c.zero = (res_c == '0);
    end

    always_comb begin
        iter_flags      = '0;
        iter_flags.zero = (iter_res == '0);
`ifdef ALU_DIV_EN
        iter_flags.ovf  = div_q & div0_q;
`endif
    end

    seq_alu_iter #(
        .DATA_WIDTH (DATA_WIDTH),
        .HILO_WIDTH (HILO_WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept & is_iter_c),
        .is_div (is_div_c),
        .a      (bus.a),
        .b      (bus.b),
        .done   (iter_done),
        .res    (iter_res)
`ifdef ALU_DIV_EN
        ,
        .rem    (iter_rem)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s_q     <= '0;
            r_q     <= '0;
            flags_q <= '0;
`ifdef ALU_DIV_EN
            div_q   <= 1'b0;
            div0_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // From DONE an accept implies out_ready, so the held result
                    // is consumed on the same edge the next op is taken.
                    if (accept) begin
                        if (is_iter_c) begin
                            state <= BUSY;
                        end else begin
                            state   <= DONE;
                            s_q     <= res_c;
                            r_q     <= '0;
                            flags_q <= flags_c;
                        end
`ifdef ALU_DIV_EN
                        div_q  <= is_div_c;
                        div0_q <= (bus.b == '0);
`endif
                    end else if ((state == DONE) && bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (iter_done) begin
                        state   <= DONE;
                        s_q     <= iter_res;
                        flags_q <= iter_flags;
`ifdef ALU_DIV_EN
                        r_q     <= div_q ? iter_rem : '0;
`else
                        r_q     <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
